timer_scheduler: RTL

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

---
 rtl/timer_scheduler.sv | 112 +++++++++++
 1 files changed

// File: rtl/timer_scheduler.sv
// Four-channel one-second countdown timer with round-robin load arbitration and a shared prescaler.
// Optional readback port (rd_sel/rd_remain) is enabled by defining TIMER_SCHEDULER_REMAIN_EN.
module timer_scheduler #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_secs,
    input  logic [3:0]  cancel,
    input  logic        pause,
`ifdef TIMER_SCHEDULER_REMAIN_EN
    input  logic [1:0]  rd_sel,
    output logic [7:0]  rd_remain,
`endif
    output logic [3:0]  grant,
    output logic [3:0]  busy,
    output logic [3:0]  expire,
    output logic        tick
);

    localparam int unsigned   PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    ptr;
    logic [1:0]    gnt_idx;
    logic [1:0]    idx;
    logic          found;
    logic [3:0]    eligible;
    logic [7:0]    remain [4];

    assign eligible = req & ~busy & ~cancel;

    // Round-robin search starts one past the last granted channel and wraps.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = idx;
                found      = 1'b1;
            end
        end
        if (rst) begin
            grant = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (!pause) begin
            tick  <= (presc == PRESC_MAX);
            presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
        end else begin
            tick  <= 1'b0;
        end
    end

    // Load and decrement are exclusive because only idle channels can be granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= '0;
            expire <= '0;
            ptr    <= 2'd3;
            // NOTE: the small remain array is explicitly reset; reset discards any countdown in progress.
            for (int i = 0; i < 4; i++) begin
                remain[i] <= '0;
            end
        end else begin
            if (found) begin
                ptr <= gnt_idx;
            end
            for (int i = 0; i < 4; i++) begin
                expire[i] <= 1'b0;
                if (cancel[i]) begin
                    busy[i]   <= 1'b0;
                    remain[i] <= '0;
                end else if (grant[i]) begin
                    remain[i] <= req_secs[8*i +: 8];
                    busy[i]   <= |req_secs[8*i +: 8];
                    expire[i] <= ~|req_secs[8*i +: 8];
                end else if (tick && busy[i]) begin
                    remain[i] <= remain[i] - 8'd1;
                    if (remain[i] == 8'd1) begin
                        busy[i]   <= 1'b0;
                        expire[i] <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef TIMER_SCHEDULER_REMAIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_remain <= '0;
        end else begin
            rd_remain <= remain[rd_sel];
        end
    end
`endif

endmodule
